// File: rtl/wb_dma_sequencer_pkg.sv
// Shared state encoding and bus constants for the word-copy DMA sequencer.
package wb_dma_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  SEL_ALL    = 4'hF;

endpackage

// File: rtl/wb_dma_txn_tracker.sv
// Flags the end of one master transaction: first cycle with active low after it was seen high.
module wb_dma_txn_tracker (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic m_start,
  input  logic m_active,
  output logic txn_done_c
);

  logic seen_active_q;

  assign txn_done_c = seen_active_q & ~m_active;

  // Active wins over start so a master that answers in the start cycle is still seen.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      seen_active_q <= 1'b0;
    end else if (m_active) begin
      seen_active_q <= 1'b1;
    end else if (m_start || txn_done_c) begin
      seen_active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_dma_sequencer.sv
// Word-copy DMA: alternates single reads and writes through one wb_master_interface.
module wb_dma_sequencer
  import wb_dma_sequencer_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             cfg_start,
  input  logic [AW-1:0]    cfg_src,
  input  logic [AW-1:0]    cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic             m_start,
  output logic [AW-1:0]    m_address,
  output logic [3:0]       m_selection,
  output logic             m_write,
  output logic [DW-1:0]    m_data_wr,
  input  logic [DW-1:0]    m_data_rd,
  input  logic             m_active
);

  state_e           state_q, state_d;
  logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d, words_done_q, words_done_d;
  logic [DW-1:0]    data_q, data_d;
  logic             abort_pend_q, abort_pend_d, abort_now;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             m_start_q, m_start_d, m_write_q, m_write_d;
  logic [AW-1:0]    m_address_q, m_address_d;
  logic [DW-1:0]    m_data_wr_q, m_data_wr_d;
  logic             txn_done_c;
  logic             unused_addr_lsbs;

  // Descriptor addresses are word aligned; the byte-offset bits are dropped.
  assign unused_addr_lsbs = ^{cfg_src[1:0], cfg_dst[1:0]};

  wb_dma_txn_tracker u_tracker (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .m_start    (m_start_q),
    .m_active   (m_active),
    .txn_done_c (txn_done_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    data_d       = data_q;
    words_done_d = words_done_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    m_start_d    = 1'b0;
    m_write_d    = m_write_q;
    m_address_d  = m_address_q;
    m_data_wr_d  = m_data_wr_q;
    abort_now    = abort_pend_q | cfg_abort;

    if (busy_q && cfg_abort) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          words_done_d = '0;
          aborted_d    = 1'b0;
          if (cfg_len != '0) begin
            src_d   = {cfg_src[AW-1:2], 2'b00};
            dst_d   = {cfg_dst[AW-1:2], 2'b00};
            len_d   = cfg_len;
            busy_d  = 1'b1;
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (txn_done_c) begin
          data_d  = m_data_rd;
          src_d   = src_q + AW'(WORD_BYTES);
          state_d = abort_now ? ST_FINISH : ST_WR_REQ;
        end
      end
      ST_WR_REQ: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (txn_done_c) begin
          dst_d        = dst_q + AW'(WORD_BYTES);
          words_done_d = words_done_q + LEN_W'(1);
          state_d      = (words_done_d == len_q || abort_now) ? ST_FINISH : ST_RD_REQ;
        end
      end
      ST_FINISH: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        aborted_d    = abort_pend_q;
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus request fields are loaded on REQ entry and held until the next REQ.
    if (state_d == ST_RD_REQ) begin
      m_start_d   = 1'b1;
      m_write_d   = 1'b0;
      m_address_d = src_d;
    end else if (state_d == ST_WR_REQ) begin
      m_start_d   = 1'b1;
      m_write_d   = 1'b1;
      m_address_d = dst_d;
      m_data_wr_d = data_d;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      data_q       <= '0;
      words_done_q <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      m_start_q    <= 1'b0;
      m_write_q    <= 1'b0;
      m_address_q  <= '0;
      m_data_wr_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      data_q       <= data_d;
      words_done_q <= words_done_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      m_start_q    <= m_start_d;
      m_write_q    <= m_write_d;
      m_address_q  <= m_address_d;
      m_data_wr_q  <= m_data_wr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign words_done  = words_done_q;
  assign m_start     = m_start_q;
  assign m_address   = m_address_q;
  assign m_selection = SEL_ALL;
  assign m_write     = m_write_q;
  assign m_data_wr   = m_data_wr_q;

endmodule

// File: tb/tb_wb_dma_sequencer.sv
// Directed bench for wb_dma_sequencer with a behavioural bus/RAM responder and copy model.
module tb_wb_dma_sequencer;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        cfg_start, cfg_abort;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        busy, done, aborted;
  logic [15:0] words_done;
  logic        m_start, m_write, m_active;
  logic [31:0] m_address, m_data_wr, m_data_rd;
  logic [3:0]  m_selection;

  always #5 wb_clk = ~wb_clk;

  wb_dma_sequencer #(.AW(32), .DW(32), .LEN_W(16)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .cfg_start   (cfg_start),
    .cfg_src     (cfg_src),
    .cfg_dst     (cfg_dst),
    .cfg_len     (cfg_len),
    .cfg_abort   (cfg_abort),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .words_done  (words_done),
    .m_start     (m_start),
    .m_address   (m_address),
    .m_selection (m_selection),
    .m_write     (m_write),
    .m_data_wr   (m_data_wr),
    .m_data_rd   (m_data_rd),
    .m_active    (m_active)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] obs_addr[$];
  logic [31:0] ram       [0:1023];
  logic [31:0] model_mem [0:1023];
  int          vectors = 0, miscompares = 0;
  int          start_cnt = 0, rd_cnt = 0, done_cnt = 0;
  logic [15:0] exp_words = 16'd0;
  bit          exp_aborted = 1'b0;
  int          bus_lat = 1, bus_act = 1;
  bit          resp_busy = 1'b0;
  logic        t_wr = 1'b0;
  logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    ram[widx(a)]       = v;
    model_mem[widx(a)] = v;
  endtask

  // Expected transaction list and memory image for one descriptor.
  function automatic void plan_copy(input logic [31:0] src, input logic [31:0] dst,
                                    input int len, input int abort_at);
    logic [31:0] s, d, v;
    int n;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    n = (abort_at > 0) ? abort_at : len;
    for (int i = 0; i < n; i++) begin
      v = model_mem[widx(s)];
      exp_q.push_back('{1'b0, s, 32'h0});
      if (abort_at == 0 || i < abort_at - 1) begin
        exp_q.push_back('{1'b1, d, v});
        model_mem[widx(d)] = v;
      end
      s += 32'd4;
      d += 32'd4;
    end
    exp_words   = (abort_at > 0) ? 16'(abort_at - 1) : 16'(len);
    exp_aborted = (abort_at > 0);
  endfunction

  task automatic check_region(input string name, input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, ram[widx(a) + i], model_mem[widx(a) + i]);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    tick();
    cfg_src   = s;
    cfg_dst   = d;
    cfg_len   = l;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < 2000) begin
      @(posedge wb_clk);
      n++;
    end
    vectors++;
    if (done_cnt == base) begin
      miscompares++;
      $display("FAIL %s: done count %0d, expected a pulse within 2000 cycles", name, done_cnt);
    end
  endtask

  task automatic wait_starts(input int target, input bit reads_only, input string name);
    int n;
    n = 0;
    while (((reads_only ? rd_cnt : start_cnt) < target) && n < 2000) begin
      @(posedge wb_clk);
      n++;
    end
    vectors++;
    if ((reads_only ? rd_cnt : start_cnt) < target) begin
      miscompares++;
      $display("FAIL %s: start count below %0d after 2000 cycles", name, target);
    end
  endtask

  // Bus responder: master latency, then active for bus_act cycles, RAM access at the end.
  initial begin
    m_active  = 1'b0;
    m_data_rd = 32'd0;
    forever begin
      @(negedge wb_clk);
      if (wb_rst === 1'b1 && m_start === 1'b1) begin
        resp_busy = 1'b1;
        t_addr    = m_address;
        t_wr      = m_write;
        t_wdata   = m_data_wr;
        repeat (bus_lat) @(negedge wb_clk);
        m_active = 1'b1;
        repeat (bus_act) @(negedge wb_clk);
        if (t_wr) ram[widx(t_addr)] = t_wdata;
        else      m_data_rd = ram[widx(t_addr)];
        m_active  = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Compare process: every transaction start, held request fields and every done pulse.
  initial begin
    forever begin
      @(negedge wb_clk);
      if (wb_rst === 1'b1) begin
        if (m_start === 1'b1) begin
          start_cnt++;
          if (!m_write) rd_cnt++;
          obs_addr.push_back(m_address);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_start: addr %h write %b, no transaction expected",
                     m_address, m_write);
          end else begin
            cur = exp_q.pop_front();
            check("txn_write", 32'(m_write), 32'(cur.wr));
            check("txn_addr", m_address, cur.addr);
            if (cur.wr) check("txn_wdata", m_data_wr, cur.data);
            check("txn_sel", 32'(m_selection), 32'hF);
          end
        end
        if (resp_busy && busy) begin
          check("hold_addr", m_address, t_addr);
          check("hold_write", 32'(m_write), 32'(t_wr));
          if (t_wr) check("hold_wdata", m_data_wr, t_wdata);
        end
        if (done === 1'b1) begin
          done_cnt++;
          check("done_words", 32'(words_done), 32'(exp_words));
          check("done_aborted", 32'(aborted), 32'(exp_aborted));
          check("done_busy_low", 32'(busy), 32'd0);
          check("done_queue_empty", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sc, rb;
    wb_rst    = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_src   = 32'd0;
    cfg_dst   = 32'd0;
    cfg_len   = 16'd0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]       = 32'hA500_0000 | 32'(i);
      model_mem[i] = 32'hA500_0000 | 32'(i);
    end

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_m_data_wr", m_data_wr, 32'd0);
    check("rst_words_done", 32'(words_done), 32'd0);
    check("rst_m_selection", 32'(m_selection), 32'hF);
    @(negedge wb_clk);
    wb_rst = 1'b1;

    // Four-word copy 0x100 -> 0x200.
    poke(32'h100, 32'h1111_1111);
    poke(32'h104, 32'h2222_2222);
    poke(32'h108, 32'h3333_3333);
    poke(32'h10C, 32'h4444_4444);
    base = done_cnt;
    sc   = start_cnt;
    plan_copy(32'h100, 32'h200, 4, 0);
    start_copy(32'h100, 32'h200, 16'd4);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done(base, "t1_done");
    tick();
    check("t1_starts", 32'(start_cnt - sc), 32'd8);
    check("t1_w0", ram[widx(32'h200)], 32'h1111_1111);
    check("t1_w1", ram[widx(32'h204)], 32'h2222_2222);
    check("t1_w2", ram[widx(32'h208)], 32'h3333_3333);
    check("t1_w3", ram[widx(32'h20C)], 32'h4444_4444);
    check("t1_words_done", 32'(words_done), 32'd4);
    check("t1_aborted", 32'(aborted), 32'd0);
    check("t1_single_done", 32'(done_cnt - base), 32'd1);

    // Zero-length descriptor: done two cycles after the start pulse, no bus activity.
    base        = done_cnt;
    sc          = start_cnt;
    exp_words   = 16'd0;
    exp_aborted = 1'b0;
    start_copy(32'h100, 32'h200, 16'd0);
    check("t2_done_c1", 32'(done), 32'd0);
    check("t2_busy_c1", 32'(busy), 32'd0);
    tick();
    check("t2_done_c2", 32'(done), 32'd1);
    check("t2_busy_c2", 32'(busy), 32'd0);
    tick();
    check("t2_done_c3", 32'(done), 32'd0);
    check("t2_busy_c3", 32'(busy), 32'd0);
    check("t2_words_done", 32'(words_done), 32'd0);
    check("t2_no_start", 32'(start_cnt - sc), 32'd0);
    check("t2_single_done", 32'(done_cnt - base), 32'd1);

    // Unaligned descriptor is word aligned on the bus.
    bus_lat = 2;
    bus_act = 2;
    base    = done_cnt;
    obs_addr.delete();
    plan_copy(32'h103, 32'h202, 1, 0);
    start_copy(32'h103, 32'h202, 16'd1);
    wait_done(base, "t3_done");
    tick();
    check("t3_obs_count", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      check("t3_rd_addr", obs_addr[0], 32'h100);
      check("t3_wr_addr", obs_addr[1], 32'h200);
    end
    check("t3_data", ram[widx(32'h200)], 32'h1111_1111);

    // Abort during the third read of a ten-word copy.
    bus_lat = 2;
    bus_act = 1;
    for (int i = 0; i < 10; i++) poke(32'h300 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    base = done_cnt;
    sc   = start_cnt;
    rb   = rd_cnt;
    plan_copy(32'h300, 32'h400, 10, 3);
    start_copy(32'h300, 32'h400, 16'd10);
    wait_starts(rb + 3, 1'b1, "t4_third_read");
    #1;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    wait_done(base, "t4_done");
    tick();
    check("t4_words_done", 32'(words_done), 32'd2);
    check("t4_aborted", 32'(aborted), 32'd1);
    check("t4_starts", 32'(start_cnt - sc), 32'd5);
    check("t4_w0", ram[widx(32'h400)], 32'hC0DE_0000);
    check("t4_w1", ram[widx(32'h404)], 32'hC0DE_0001);
    check("t4_w2_untouched", ram[widx(32'h408)], 32'hA500_0102);
    check("t4_w9_untouched", ram[widx(32'h424)], 32'hA500_0109);
    check_region("t4_region", 32'h400, 10);

    // Start while busy is dropped; later start in IDLE clears aborted.
    bus_lat = 1;
    bus_act = 2;
    check("t5_aborted_before", 32'(aborted), 32'd1);
    base = done_cnt;
    sc   = start_cnt;
    plan_copy(32'h100, 32'h500, 3, 0);
    start_copy(32'h100, 32'h500, 16'd3);
    check("t5_aborted_cleared", 32'(aborted), 32'd0);
    repeat (3) tick();
    start_copy(32'h300, 32'h600, 16'd7);
    wait_done(base, "t5_done");
    tick();
    check("t5_words_done", 32'(words_done), 32'd3);
    check("t5_starts", 32'(start_cnt - sc), 32'd6);
    check_region("t5_region", 32'h500, 3);
    check("t5_no_second", ram[widx(32'h600)], 32'hA500_0180);
    base = done_cnt;
    plan_copy(32'h300, 32'h600, 2, 0);
    start_copy(32'h300, 32'h600, 16'd2);
    check("t5_later_busy", 32'(busy), 32'd1);
    wait_done(base, "t5_later_done");
    tick();
    check_region("t5_later_region", 32'h600, 2);

    // Reset while the first write is in flight.
    bus_lat = 2;
    bus_act = 1;
    base = done_cnt;
    sc   = start_cnt;
    plan_copy(32'h100, 32'h680, 4, 0);
    start_copy(32'h100, 32'h680, 16'd4);
    wait_starts(sc + 2, 1'b0, "t6_first_write");
    #3;
    wb_rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_m_start_rst", 32'(m_start), 32'd0);
    check("t6_done_rst", 32'(done), 32'd0);
    check("t6_words_rst", 32'(words_done), 32'd0);
    check("t6_addr_rst", m_address, 32'd0);
    for (int n = 0; n < 50 && resp_busy; n++) @(negedge wb_clk);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
    check("t6_no_done", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    plan_copy(32'h300, 32'h700, 2, 0);
    start_copy(32'h300, 32'h700, 16'd2);
    wait_done(base, "t6_done");
    tick();
    check("t6_w0", ram[widx(32'h700)], 32'hC0DE_0000);
    check("t6_w1", ram[widx(32'h704)], 32'hC0DE_0001);
    check("t6_words_done", 32'(words_done), 32'd2);
    check("t6_aborted", 32'(aborted), 32'd0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_dma_sequencer.md
Name: wb_dma_sequencer

Overview:
Word-copy DMA controller that sequences a single wb_master_interface instance. It accepts a copy descriptor (source, destination, length in 32-bit words) and issues alternating single read/write transactions through the master interface's start/active handshake. It moves data between wb_ram slaves on the bus matrix without CPU involvement. It sits between a control source (register block or testbench) and wb_master_interface.

Parameters:
AW, 32, address width (byte addresses)
DW, 32, data width; only 32 is supported
LEN_W, 16, width of the word-count field; maximum copy is 2^LEN_W-1 words

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-low
cfg_start  in  1  one-cycle pulse; latches cfg_src/cfg_dst/cfg_len
cfg_src  in  AW  source byte address; bits [1:0] ignored
cfg_dst  in  AW  destination byte address; bits [1:0] ignored
cfg_len  in  LEN_W  number of words to copy
cfg_abort  in  1  level/pulse; stop after the in-flight transaction
busy  out  1  high from the cycle after accepted cfg_start until done
done  out  1  one-cycle pulse at end of copy (normal or aborted)
aborted  out  1  sticky; set with done if the copy was aborted; cleared by next accepted cfg_start
words_done  out  LEN_W  count of completed write transactions in the current or last copy
m_start  out  1  one-cycle pulse to wb_master_interface.start
m_address  out  AW  to wb_master_interface.address; held stable while a transaction is in flight
m_selection  out  4  to wb_master_interface.selection; always 4'hF
m_write  out  1  to wb_master_interface.write
m_data_wr  out  DW  to wb_master_interface.data_wr
m_data_rd  in  DW  from wb_master_interface.data_rd
m_active  in  1  from wb_master_interface.active

Behaviour:
- Reset (wb_rst low, asynchronous): state IDLE; busy, done, aborted, m_start and m_write = 0; m_address, m_data_wr and words_done = 0; m_selection = 4'hF; internal counters and data register = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE:
  - On cfg_start with cfg_len != 0: latch src/dst with bits [1:0] forced to 0, latch len, clear words_done and aborted, set busy, go to RD_REQ.
  - On cfg_start with cfg_len == 0: no bus activity; go to FINISH. done pulses 2 cycles after cfg_start.
  - cfg_abort in IDLE is ignored. If cfg_start and cfg_abort are both high in IDLE, start is accepted and abort is ignored.
- RD_REQ: m_address = src, m_write = 0, m_start = 1 for exactly one cycle. Clear the seen_active flag. Go to RD_WAIT.
- RD_WAIT:
  - Set seen_active when m_active = 1.
  - Completion is the first cycle with seen_active = 1 and m_active = 0.
  - On completion: capture m_data_rd into the data register, src += 4, go to WR_REQ.
- WR_REQ: m_address = dst, m_write = 1, m_data_wr = data register, one-cycle m_start. Go to WR_WAIT.
- WR_WAIT:
  - Completion is detected as in RD_WAIT.
  - On completion: dst += 4, words_done += 1.
  - If words_done+1 == len or abort_pending, go to FINISH; else go to RD_REQ.
- FINISH: done = 1 for one cycle, busy = 0, aborted = abort_pending. Clear abort_pending. Go to IDLE.
- Abort:
  - cfg_abort sampled high while busy sets abort_pending.
  - Bus transactions are never cut. An abort during RD_* still completes the read, skips the write, and goes to FINISH.
  - words_done reflects only completed writes.
- cfg_start while busy is ignored; the descriptor is not queued.
- Address arithmetic is modulo 2^AW: 0xFFFFFFFC + 4 wraps to 0x00000000 with no error.
- m_address, m_write and m_data_wr hold their values from the REQ state through the end of the matching WAIT state.
- Minimum per-word cost: 2 cycles (REQ, WAIT) plus master latency, for each of the read and the write.
- Reset mid-copy: immediate return to the reset values above; no done pulse.

Decomposition:
- Shared include wb_dma_defines.vh:
  - state encodings (3-bit localparams);
  - WORD_BYTES = 4;
  - SEL_ALL = 4'hF.
- One sub-module is natural: wb_dma_txn_tracker. It holds the seen_active flag and outputs a one-cycle txn_done on the first active-low after active-high following m_start. It is reused by the RD_WAIT and WR_WAIT states.
- Counters and address registers stay in the top level.

Test Plan:
- Preload ram0 words 0x100..0x10C with 0x11111111, 0x22222222, 0x33333333, 0x44444444; cfg_src = 0x100, cfg_dst = 0x200, cfg_len = 4 -> exactly 8 m_start pulses alternating R/W; ram words 0x200..0x20C match the source; words_done = 4; single done pulse; aborted = 0.
- cfg_len = 0 -> no m_start; busy stays 0 after the pulse; done exactly 2 cycles after cfg_start; words_done = 0.
- cfg_src = 0x103, cfg_dst = 0x202, cfg_len = 1 -> m_address driven 0x100 then 0x200; m_selection = 4'hF throughout.
- cfg_len = 10; assert cfg_abort during the 3rd read -> the read completes, no 3rd write is issued, done pulses, aborted = 1, words_done = 2, destination words 2..9 untouched.
- Second cfg_start while busy with different descriptor -> ignored; the original copy completes with its own length; a later start in IDLE is accepted and clears aborted.
- Assert wb_rst low mid-WR_WAIT -> busy, m_start and done go to 0 asynchronously; after release a new copy of 2 words completes correctly.
